// File: rtl/m2p_mux_indication.sv
// Merges NUM_METHODS indication methods onto one pipe: per-channel FIFOs, round-robin grant, registered output word.
// Latency: 2 cycles from accepted write to enq__ENA (empty system, enq__RDY high); 1 message/cycle aggregate throughput.
// Backpressure: enq__RDY low holds the output word; channels keep accepting until their own FIFO is full (out__RDY low).
module m2p_mux_indication #(
  parameter int NUM_METHODS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int BASE_ID     = 0,
  parameter int MSG_LEN     = 64
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_METHODS-1:0]            out__ENA,
  input  logic [NUM_METHODS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_METHODS-1:0]            out__RDY,
  output logic                              enq__ENA,
  output logic [DATA_WIDTH+47:0]            enq_v,
  input  logic                              enq__RDY,
  output logic [31:0]                       msg_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // channel FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem    [NUM_METHODS][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr [NUM_METHODS];
  logic [AW-1:0]         rd_ptr [NUM_METHODS];
  logic [CW-1:0]         cnt    [NUM_METHODS];
  logic [NUM_METHODS-1:0] push;
  logic [NUM_METHODS-1:0] pop;

  // arbiter and output stage
  logic [PW-1:0]          p;
  logic [PW-1:0]          g;
  logic                   found;
  logic                   load;
  int                     idx;
  logic [DATA_WIDTH-1:0]  head;
  logic [15:0]            grant_id;
  logic                   out_valid;
  logic [DATA_WIDTH+47:0] out_word;

  // ready comes from the registered count only; a same-cycle pop never frees a full FIFO early
  always_comb begin
    out__RDY = '0;
    push     = '0;
    for (int i = 0; i < NUM_METHODS; i++) begin
      out__RDY[i] = (cnt[i] != FULL_CNT) & ~RST;
      push[i]     = out__ENA[i] & out__RDY[i];
    end
  end

  // round-robin search starting at p; first non-empty channel wins
  always_comb begin
    found = 1'b0;
    g     = '0;
    head  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_METHODS; k++) begin
      idx = int'(p) + k;
      if (idx >= NUM_METHODS) idx = idx - NUM_METHODS;
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        g     = PW'(idx);
        head  = mem[idx][rd_ptr[idx]];
      end
    end
  end

  assign load     = found & (~out_valid | enq__RDY);
  assign grant_id = 16'(BASE_ID) + 16'(g);
  assign enq__ENA = out_valid & enq__RDY;
  assign enq_v    = out_word;

  // pop only the granted channel, and only when the output register takes the word
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_METHODS; i++) begin
      pop[i] = load & (int'(g) == i);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_METHODS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_METHODS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] & ~pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (pop[i] & ~push[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // FIFO payload storage needs no reset; occupancy guards every read
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_METHODS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= out_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // output register, arbiter pointer and delivered-message counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      p         <= '0;
      msg_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= {16'd0, grant_id, head, 16'(MSG_LEN)};
        p         <= (int'(g) + 1 >= NUM_METHODS) ? '0 : PW'(int'(g) + 1);
      end else if (enq__RDY) begin
        out_valid <= 1'b0;
      end
      if (enq__ENA) msg_count <= msg_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_m2p_mux_indication.sv
// Directed bench for m2p_mux_indication: cycle table plus round-robin and id-wrap sequences.
// Two instances share stimulus; the second uses BASE_ID 16'hFFFF to expose id wrap.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_m2p_mux_indication;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  out__ENA;
  logic [127:0] out_data;
  logic        enq__RDY;
  logic [3:0]  out__RDY,  out__RDY_w;
  logic        enq__ENA,  enq__ENA_w;
  logic [79:0] enq_v,     enq_v_w;
  logic [31:0] msg_count, msg_count_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  m2p_mux_indication #(.NUM_METHODS(4), .DATA_WIDTH(32), .FIFO_DEPTH(4), .BASE_ID(0), .MSG_LEN(64)) dut (
    .CLK(CLK), .RST(RST), .out__ENA(out__ENA), .out_data(out_data), .out__RDY(out__RDY),
    .enq__ENA(enq__ENA), .enq_v(enq_v), .enq__RDY(enq__RDY), .msg_count(msg_count));

  m2p_mux_indication #(.NUM_METHODS(4), .DATA_WIDTH(32), .FIFO_DEPTH(4), .BASE_ID(16'hFFFF), .MSG_LEN(64)) dut_w (
    .CLK(CLK), .RST(RST), .out__ENA(out__ENA), .out_data(out_data), .out__RDY(out__RDY_w),
    .enq__ENA(enq__ENA_w), .enq_v(enq_v_w), .enq__RDY(enq__RDY), .msg_count(msg_count_w));

  // delivered words from the BASE_ID=0 instance
  logic [79:0] q0[$];
  always @(negedge CLK) begin
    if (enq__ENA === 1'b1) q0.push_back(enq_v);
  end

  typedef struct {
    logic        rst;
    logic [3:0]  ena;
    logic [31:0] d;
    logic        erdy;
    logic [3:0]  xrdy;
    logic        xenq;
    logic [3:0]  xid;
    logic [31:0] xd;
    logic [31:0] xmc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] ena, logic [31:0] d, logic erdy,
                              logic [3:0] xrdy, logic xenq, logic [3:0] xid, logic [31:0] xd, logic [31:0] xmc);
    vec_t v;
    v.rst = rst; v.ena = ena; v.d = d; v.erdy = erdy;
    v.xrdy = xrdy; v.xenq = xenq; v.xid = xid; v.xd = xd; v.xmc = xmc;
    return v;
  endfunction

  function automatic logic [79:0] word(logic [15:0] id, logic [31:0] d);
    return {16'd0, id, d, 16'd64};
  endfunction

  function automatic logic [31:0] rr_data(int c, int k);
    return 32'hC0DE_0000 | 32'(c << 8) | 32'(k);
  endfunction

  task automatic chk(input string nm, input int row, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
    end
  endtask

  task automatic drive(input logic rst_i, input logic [3:0] ena_i, input logic [31:0] d_i, input logic erdy_i);
    RST      = rst_i;
    out__ENA = ena_i;
    enq__RDY = erdy_i;
    for (int c = 0; c < 4; c++) begin
      out_data[c*32 +: 32] = ena_i[c] ? d_i : (32'hBAD0_0000 | 32'(c));
    end
  endtask

  int          sent[4];
  int          budget;
  bit          all_sent;
  bit          seen;
  logic [79:0] cap0, cap1;

  initial begin
    // reset, single message, backpressure/full, full with pop, reset mid-operation
    tbl.push_back(mk(1, 4'h0, 32'h0,          1, 4'h0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h4, 32'hDEADBEEF,   1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 2, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0000,  0, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0001,  0, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0002,  0, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0003,  0, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0004,  0, 4'hF, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h1111_0005,  0, 4'hE, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,          0, 4'hE, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hE, 1, 0, 32'h1111_0000, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 0, 32'h1111_0001, 2));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 0, 32'h1111_0002, 3));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 0, 32'h1111_0003, 4));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 0, 32'h1111_0004, 5));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0000,  0, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0001,  0, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0002,  0, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0003,  0, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0004,  0, 4'hF, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0005,  1, 4'hD, 1, 1, 32'h2222_0000, 6));
    tbl.push_back(mk(0, 4'h2, 32'h2222_0005,  0, 4'hF, 0, 0, 32'h0, 7));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hD, 1, 1, 32'h2222_0001, 7));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 1, 32'h2222_0002, 8));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 1, 32'h2222_0003, 9));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 1, 32'h2222_0004, 10));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 1, 32'h2222_0005, 11));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 12));
    tbl.push_back(mk(0, 4'h7, 32'h3333_0000,  0, 4'hF, 0, 0, 32'h0, 12));
    tbl.push_back(mk(0, 4'h0, 32'h0,          0, 4'hF, 0, 0, 32'h0, 12));
    tbl.push_back(mk(1, 4'h0, 32'h0,          0, 4'h0, 0, 0, 32'h0, 12));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'hA, 32'h4444_0000,  1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 1, 32'h4444_0000, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 1, 3, 32'h4444_0000, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,          1, 4'hF, 0, 0, 32'h0, 2));

    drive(1'b1, 4'h0, 32'h0, 1'b1);
    repeat (2) @(posedge CLK);

    foreach (tbl[r]) begin
      @(posedge CLK); #1;
      drive(tbl[r].rst, tbl[r].ena, tbl[r].d, tbl[r].erdy);
      @(negedge CLK);
      chk("out_rdy", r, 80'(out__RDY), 80'(tbl[r].xrdy));
      chk("enq_ena", r, 80'(enq__ENA), 80'(tbl[r].xenq));
      chk("msg_count", r, 80'(msg_count), 80'(tbl[r].xmc));
      if (tbl[r].xenq) begin
        chk("enq_v", r, enq_v, word(16'(tbl[r].xid), tbl[r].xd));
        chk("enq_v_base_ffff", r, enq_v_w, word(16'(tbl[r].xid) + 16'hFFFF, tbl[r].xd));
      end
    end

    // round-robin: every channel offers 8 words back to back, retrying while not ready
    q0.delete();
    for (int c = 0; c < 4; c++) sent[c] = 0;
    budget   = 0;
    all_sent = 1'b0;
    while (!all_sent && budget < 300) begin
      @(posedge CLK); #1;
      RST      = 1'b0;
      enq__RDY = 1'b1;
      for (int c = 0; c < 4; c++) begin
        out__ENA[c]          = (sent[c] < 8);
        out_data[c*32 +: 32] = rr_data(c, sent[c]);
      end
      @(negedge CLK);
      for (int c = 0; c < 4; c++) begin
        if (out__ENA[c] && out__RDY[c]) sent[c]++;
      end
      all_sent = (sent[0] == 8) && (sent[1] == 8) && (sent[2] == 8) && (sent[3] == 8);
      budget++;
    end
    chk("rr_all_accepted", 0, 80'(all_sent), 80'd1);
    @(posedge CLK); #1;
    drive(1'b0, 4'h0, 32'h0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("rr_count", 0, 80'(q0.size()), 80'd32);
    for (int m = 0; m < 32; m++) begin
      chk("rr_msg", m, (m < q0.size()) ? q0[m] : 80'd0, word(16'(m % 4), rr_data(m % 4, m / 4)));
    end
    chk("rr_msg_count", 0, 80'(msg_count), 80'd34);

    // id wrap: channel 1 with BASE_ID 16'hFFFF lands on id 0
    @(posedge CLK); #1;
    drive(1'b0, 4'h2, 32'h5555_0001, 1'b1);
    @(posedge CLK); #1;
    drive(1'b0, 4'h0, 32'h0, 1'b1);
    seen = 1'b0;
    cap0 = '0;
    cap1 = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (enq__ENA === 1'b1) begin
        cap0 = enq_v;
        cap1 = enq_v_w;
        seen = 1'b1;
        break;
      end
    end
    chk("wrap_seen", 0, 80'(seen), 80'd1);
    chk("wrap_id_base0", 0, 80'(cap0[63:48]), 80'h0001);
    chk("wrap_id_baseffff", 0, 80'(cap1[63:48]), 80'h0000);
    chk("wrap_word", 0, cap1, {16'd0, 16'h0000, 32'h5555_0001, 16'd64});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
